// File: rtl/switch_debounce4_pkg.sv
// Board-level constants shared by the switch conditioning blocks.
package switch_debounce4_pkg;

  // Board oscillator and the settle time a slide switch needs.
  localparam int unsigned BOARD_CLK_HZ    = 32'd100_000_000;
  localparam int unsigned DEBOUNCE_MS     = 32'd10;
  localparam int unsigned DEFAULT_CNT_MAX = (BOARD_CLK_HZ / 32'd1000) * DEBOUNCE_MS;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) begin
      cnt_width = 32'd1;
    end else begin
      cnt_width = $clog2(n);
    end
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One switch channel: two-flop synchroniser, stability counter, clean level
// and one-cycle rise/fall strobes.
module debounce_ch
  import switch_debounce4_pkg::*;
#(
  parameter int unsigned CNT_MAX = DEFAULT_CNT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_db,
  output logic sw_rise,
  output logic sw_fall,
  output logic evt_d
);

  localparam int unsigned     CW       = cnt_width(CNT_MAX);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 32'd1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(32'd0);

  logic          s1_q;
  logic          s2_q;
  logic          stb_q,  stb_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q,  cnt_d;

  // Next-state: count while the synchronised level differs from the stable
  // level; any return to the stable level throws the count away.
  always_comb begin
    stb_d  = stb_q;
    cnt_d  = CNT_ZERO;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q != stb_q) begin
      if (cnt_q == CNT_LAST) begin
        stb_d  = s2_q;
        cnt_d  = CNT_ZERO;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Synchroniser, counter, stable level and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      stb_q  <= 1'b0;
      cnt_q  <= CNT_ZERO;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= sw_raw;
      s2_q   <= s1_q;
      stb_q  <= stb_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sw_db   = stb_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
  // Strobe about to be issued; lets the parent register a summary pulse
  // that lines up with sw_rise/sw_fall.
  assign evt_d   = rise_d | fall_d;

endmodule

// File: rtl/switch_debounce4.sv
// Four-channel slide-switch conditioner feeding the reduction-gate stage.
module switch_debounce4
  import switch_debounce4_pkg::*;
#(
  parameter int unsigned WIDTH   = 32'd4,
  parameter int unsigned CNT_MAX = DEFAULT_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  logic [WIDTH-1:0] evt_d;
  logic             changed_q, changed_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    debounce_ch #(
      .CNT_MAX (CNT_MAX)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_raw  (sw_raw[gi]),
      .sw_db   (sw_db[gi]),
      .sw_rise (sw_rise[gi]),
      .sw_fall (sw_fall[gi]),
      .evt_d   (evt_d[gi])
    );
  end

  // Any channel about to strobe makes changed fire in the same cycle.
  always_comb begin
    changed_d = 1'b0;
    if (|evt_d) begin
      changed_d = 1'b1;
    end else begin
      changed_d = 1'b0;
    end
  end

  // Registered summary pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;

endmodule

// File: tb/tb_switch_debounce4.sv
// Directed bench for switch_debounce4 with CNT_MAX = 4 (latency 6 edges).
module tb_switch_debounce4;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_raw;
  logic [3:0] sw_db;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       changed;

  int n_tests;
  int n_fail;

  switch_debounce4 #(
    .WIDTH   (32'd4),
    .CNT_MAX (32'd4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_db   (sw_db),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] db, input logic [3:0] rise,
                         input logic [3:0] fall, input logic chg);
    chk({tag, "_db"},   sw_db,   db);
    chk({tag, "_rise"}, sw_rise, rise);
    chk({tag, "_fall"}, sw_fall, fall);
    chk({tag, "_chg"},  {3'b000, changed}, {3'b000, chg});
  endtask

  initial begin
    logic [9:0] bpat;
    n_tests = 0;
    n_fail  = 0;

    // Reset held with all switches high: everything stays at zero.
    rst_n  = 1'b0;
    sw_raw = 4'hF;
    step(3);
    chk_all("rst_hold", 4'h0, 4'h0, 4'h0, 1'b0);

    // Release; switches held high report a rise after edge 5.
    rst_n = 1'b1;
    step(5);
    chk_all("rst_e4", 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    chk_all("rst_e5", 4'hF, 4'hF, 4'h0, 1'b1);
    step(1);
    chk_all("rst_e6", 4'hF, 4'h0, 4'h0, 1'b0);

    // Return to all-low.
    sw_raw = 4'h0;
    step(6);
    chk_all("fall_e5", 4'h0, 4'h0, 4'hF, 1'b1);
    step(1);
    chk_all("fall_e6", 4'h0, 4'h0, 4'h0, 1'b0);

    // Single clean change 0 -> 2.
    sw_raw = 4'h2;
    step(5);
    chk_all("clean_e4", 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    chk_all("clean_e5", 4'h2, 4'h2, 4'h0, 1'b1);
    step(1);
    chk_all("clean_e6", 4'h2, 4'h0, 4'h0, 1'b0);

    // Bounce on bit 0: raw seen at edges 0..9 is 1,1,0,0,1,1,...
    // s2 stays high from edge 5 on, so the rise lands after edge 9.
    bpat   = 10'b11_1111_0011;
    sw_raw = {3'b001, bpat[0]};
    for (int i = 0; i < 9; i++) begin
      step(1);
      sw_raw = {3'b001, bpat[i + 1]};
      chk("bounce_db",  sw_db,  4'h2);
      chk("bounce_chg", {3'b000, changed}, 4'h0);
    end
    step(1);
    chk_all("bounce_e9", 4'h3, 4'h1, 4'h0, 1'b1);
    step(1);
    chk_all("bounce_e10", 4'h3, 4'h0, 4'h0, 1'b0);

    // Glitch on bit 3: high for edges 0..2 only, then low again.
    sw_raw = 4'hB;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i == 2) sw_raw = 4'h3;
      chk("glitch_db",   sw_db,   4'h3);
      chk("glitch_rise", sw_rise, 4'h0);
      chk("glitch_chg",  {3'b000, changed}, 4'h0);
    end

    // Move to 5 (bit1 falls, bit2 rises), then 5 -> A in one cycle.
    sw_raw = 4'h5;
    step(6);
    chk_all("to5_e5", 4'h5, 4'h4, 4'h2, 1'b1);
    step(1);
    sw_raw = 4'hA;
    step(5);
    chk_all("simul_e4", 4'h5, 4'h0, 4'h0, 1'b0);
    step(1);
    chk_all("simul_e5", 4'hA, 4'hA, 4'h5, 1'b1);
    step(1);
    chk_all("simul_e6", 4'hA, 4'h0, 4'h0, 1'b0);

    // Reset in the middle of a pending A -> F change.
    sw_raw = 4'hF;
    step(4);
    chk_all("mid_e3", 4'hA, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all("mid_async", 4'h0, 4'h0, 4'h0, 1'b0);
    step(2);
    chk_all("mid_hold", 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    step(5);
    chk_all("mid_rel_e4", 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    chk_all("mid_rel_e5", 4'hF, 4'hF, 4'h0, 1'b1);
    step(1);
    chk_all("mid_rel_e6", 4'hF, 4'h0, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
